// File: rtl/i2c_master_seq_pkg.sv
// Shared definitions for the I2C master sequencer: command-entry control bits,
// response error bits, FSM state encoding, the captured request record and
// the entry-count helper.
package i2c_master_seq_pkg;

  // fifo_snd_ctl bit positions
  localparam int unsigned CtlStart  = 0;
  localparam int unsigned CtlDrive  = 1;
  localparam int unsigned CtlRecv   = 2;
  localparam int unsigned CtlStop   = 3;
  localparam int unsigned CtlRepeat = 4;
  localparam int unsigned CtlW      = 5;

  // RSP_ERR bit positions
  localparam int unsigned ErrNack  = 0;
  localparam int unsigned ErrAbort = 1;

  // Longest sequence is a 4-byte read: addr, reg, re-addr, 4 receives
  localparam int unsigned MaxEntries = 7;
  localparam int unsigned IdxW       = $clog2(MaxEntries + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain,
    StResp
  } state_e;

  typedef struct packed {
    logic        rw;
    logic [6:0]  dev;
    logic [7:0]  reg_addr;
    logic [1:0]  len;
    logic [31:0] wdata;
  } req_t;

  // Number of command entries a request expands to
  function automatic logic [IdxW-1:0] entry_count(input logic rw, input logic [1:0] len);
    return rw ? IdxW'(4) + IdxW'(len) : IdxW'(3) + IdxW'(len);
  endfunction

endpackage

// File: rtl/i2c_master_seq_entry.sv
// Maps an entry index plus the captured request to the byte and control word
// that the sequencer pushes into the send FIFO. Purely combinational.
module i2c_master_seq_entry
  import i2c_master_seq_pkg::*;
(
  input  logic [IdxW-1:0] idx_i,
  input  req_t            req_i,
  output logic [7:0]      dat_o,
  output logic [CtlW-1:0] ctl_o
);

  logic [IdxW-1:0] last_idx;
  logic [1:0]      wbyte;

  assign last_idx = entry_count(req_i.rw, req_i.len) - IdxW'(1);
  // Write payload starts at entry 2, LSB first
  assign wbyte    = 2'(idx_i - IdxW'(2));

  // Decode the entry index into address, register, re-address or data phases
  always_comb begin
    dat_o = '0;
    ctl_o = '0;
    if (idx_i == '0) begin
      dat_o           = {req_i.dev, 1'b0};
      ctl_o[CtlStart] = 1'b1;
      ctl_o[CtlDrive] = 1'b1;
    end else if (idx_i == IdxW'(1)) begin
      dat_o           = req_i.reg_addr;
      ctl_o[CtlDrive] = 1'b1;
    end else if (req_i.rw && idx_i == IdxW'(2)) begin
      dat_o            = {req_i.dev, 1'b1};
      ctl_o[CtlRepeat] = 1'b1;
      ctl_o[CtlDrive]  = 1'b1;
    end else if (req_i.rw) begin
      dat_o           = 8'hFF;
      ctl_o[CtlRecv]  = 1'b1;
      ctl_o[CtlStop]  = (idx_i == last_idx);
    end else begin
      dat_o           = req_i.wdata[{wbyte, 3'b000} +: 8];
      ctl_o[CtlDrive] = 1'b1;
      ctl_o[CtlStop]  = (idx_i == last_idx);
    end
  end

endmodule

// File: rtl/i2c_master_seq.sv
// I2C master sequencer: turns a register read/write request into a list of
// byte-level commands for an I2C engine, kicks the engine, drains its receive
// FIFO and returns data plus NACK/abort status.
// Optional: define I2C_MASTER_SEQ_TIMEOUT_EN to abort RUN after P_TIMEOUT_CYC cycles.
module i2c_master_seq
  import i2c_master_seq_pkg::*;
#(
  parameter int unsigned P_TIMEOUT_CYC = 32'd1_000_000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REQ_VLD,
  output logic        REQ_RDY,
  input  logic        REQ_RW,
  input  logic [6:0]  REQ_DEV,
  input  logic [7:0]  REQ_REG,
  input  logic [1:0]  REQ_LEN,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VLD,
  input  logic        RSP_RDY,
  output logic [31:0] RSP_RDATA,
  output logic [1:0]  RSP_ERR,
  input  logic        fifo_snd_rdy,
  output logic        fifo_snd_vld,
  output logic [7:0]  fifo_snd_dat,
  output logic [4:0]  fifo_snd_ctl,
  output logic        fifo_rcv_rdy,
  input  logic        fifo_rcv_vld,
  input  logic [7:0]  fifo_rcv_dat,
  input  logic        fifo_rcv_ack,
  input  logic        I2C_EN,
  output logic        I2C_GO,
  output logic [7:0]  I2C_RUN_NUM,
  input  logic        I2C_DONE
);

  state_e          state_q, state_d;
  req_t            req_q, req_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      err_q, err_d;

  logic [IdxW-1:0] num;
  logic [IdxW-1:0] last_idx;
  logic [1:0]      rcv_byte;
  logic [7:0]      ent_dat;
  logic [CtlW-1:0] ent_ctl;
  logic            tmo_hit;
  logic            abort;

  assign num      = entry_count(req_q.rw, req_q.len);
  assign last_idx = num - IdxW'(1);
  // Receive entries start at index 3; first received byte lands in byte 0
  assign rcv_byte = 2'(idx_q - IdxW'(3));

  // Same index walks the send list in LOAD and the receive items in DRAIN
  i2c_master_seq_entry u_entry (
    .idx_i (idx_q),
    .req_i (req_q),
    .dat_o (ent_dat),
    .ctl_o (ent_ctl)
  );

`ifdef I2C_MASTER_SEQ_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;

  // Count cycles spent waiting for DONE
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tmo_cnt_q <= '0;
    end else if (state_q != StRun) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end
  end

  assign tmo_hit = (state_q == StRun) && (tmo_cnt_q == 32'(P_TIMEOUT_CYC - 1));
`else
  logic unused_tmo_cyc;
  assign unused_tmo_cyc = ^P_TIMEOUT_CYC;
  assign tmo_hit        = 1'b0;
`endif

  assign abort = ((state_q == StLoad) || (state_q == StRun) || (state_q == StDrain)) &&
                 (!I2C_EN || tmo_hit);

  // State and captured-request registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      req_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state: capture, push entries, wait for DONE, drain, respond
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (abort) begin
      state_d         = StResp;
      rdata_d         = '0;
      err_d           = '0;
      err_d[ErrAbort] = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (REQ_VLD && REQ_RDY) begin
            req_d   = {REQ_RW, REQ_DEV, REQ_REG, REQ_LEN, REQ_WDATA};
            idx_d   = '0;
            rdata_d = '0;
            err_d   = '0;
            state_d = StLoad;
          end
        end
        StLoad: begin
          if (fifo_snd_rdy) begin
            if (idx_q == last_idx) begin
              state_d = StRun;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
        StRun: begin
          if (I2C_DONE) begin
            idx_d   = '0;
            state_d = StDrain;
          end
        end
        StDrain: begin
          if (fifo_rcv_vld) begin
            if (ent_ctl[CtlDrive] && !fifo_rcv_ack) begin
              err_d[ErrNack] = 1'b1;
            end
            if (ent_ctl[CtlRecv]) begin
              rdata_d[{rcv_byte, 3'b000} +: 8] = fifo_rcv_dat;
            end
            if (idx_q == last_idx) begin
              state_d = StResp;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
        StResp: begin
          if (RSP_RDY) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from state; everything reads zero outside its phase
  always_comb begin
    REQ_RDY      = 1'b0;
    RSP_VLD      = 1'b0;
    RSP_RDATA    = '0;
    RSP_ERR      = '0;
    fifo_snd_vld = 1'b0;
    fifo_snd_dat = '0;
    fifo_snd_ctl = '0;
    fifo_rcv_rdy = 1'b0;
    I2C_GO       = 1'b0;
    I2C_RUN_NUM  = '0;
    unique case (state_q)
      StIdle: begin
        // RESET_N term keeps REQ_RDY low while reset is held
        REQ_RDY = I2C_EN && RESET_N;
      end
      StLoad: begin
        fifo_snd_vld = 1'b1;
        fifo_snd_dat = ent_dat;
        fifo_snd_ctl = ent_ctl;
        I2C_RUN_NUM  = 8'(num);
      end
      StRun: begin
        I2C_GO      = 1'b1;
        I2C_RUN_NUM = 8'(num);
      end
      StDrain: begin
        fifo_rcv_rdy = 1'b1;
        I2C_RUN_NUM  = 8'(num);
      end
      StResp: begin
        RSP_VLD   = 1'b1;
        RSP_RDATA = rdata_q;
        RSP_ERR   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/i2c_master_seq.md
I2C_MASTER_SEQ -- requirements
Module: i2c_master_seq

Interface
REQ-001 SHALL have parameter P_TIMEOUT_CYC, default 32'd1_000_000, DONE watchdog limit in CLK cycles.
REQ-002 SHALL have ports CLK input 1 system clock; RESET_N input 1 asynchronous active-low reset.
REQ-003 SHALL have REQ_VLD in 1, REQ_RDY out 1, REQ_RW in 1 (0=write, 1=read), REQ_DEV in 7 (7-bit address), REQ_REG in 8 (register index), REQ_LEN in 2 (bytes=REQ_LEN+1), REQ_WDATA in 32.
REQ-004 SHALL have RSP_VLD out 1, RSP_RDY in 1, RSP_RDATA out 32, RSP_ERR out 2 (bit0 NACK, bit1 abort/timeout).
REQ-005 SHALL have fifo_snd_rdy in 1, fifo_snd_vld out 1, fifo_snd_dat out 8, fifo_snd_ctl out 5 (bit0 start, 1 drive, 2 receive, 3 stop, 4 repeat).
REQ-006 SHALL have fifo_rcv_rdy out 1, fifo_rcv_vld in 1, fifo_rcv_dat in 8, fifo_rcv_ack in 1 (1=slave/master ACK seen).
REQ-007 SHALL have I2C_EN in 1, I2C_GO out 1, I2C_RUN_NUM out 8, I2C_DONE in 1.

Function
REQ-008 SHALL implement states IDLE, LOAD, RUN, DRAIN, RESP; REQ_RDY=1 only in IDLE with I2C_EN=1.
REQ-009 SHALL capture all REQ_* fields on REQ_VLD&REQ_RDY and enter LOAD next cycle.
REQ-010 Write SHALL emit 2+N entries: {dev<<1|0, start|drive}, {reg, drive}, WDATA bytes LSB-first with drive, last byte drive|stop.
REQ-011 Read SHALL emit 3+N entries: {dev<<1|0, start|drive}, {reg, drive}, {dev<<1|1, repeat|drive}, N x {8'hFF, receive}, last receive|stop.
REQ-012 LOAD SHALL present one entry per cycle, advancing only on fifo_snd_vld&fifo_snd_rdy; vld/dat/ctl held stable while rdy=0.
REQ-013 I2C_RUN_NUM SHALL equal the entry count (zero-extended) from LOAD through DRAIN, 0 in IDLE.
REQ-014 After the last entry is accepted, I2C_GO SHALL assert next cycle (RUN) and stay high until the cycle after I2C_DONE=1 is sampled.
REQ-015 DRAIN SHALL hold fifo_rcv_rdy=1 and pop exactly RUN_NUM items; extra items remain in the FIFO untouched.
REQ-016 In DRAIN, any drive-entry item with fifo_rcv_ack=0 SHALL set RSP_ERR[0]; receive-item data SHALL shift into RSP_RDATA byte 0 first, unused upper bytes 0.
REQ-017 Write response RSP_RDATA SHALL be 32'h0.
REQ-018 RESP SHALL hold RSP_VLD=1 with stable data until RSP_VLD&RSP_RDY, then return to IDLE (next request accepted earliest one cycle later).
REQ-019 I2C_EN falling in LOAD, RUN or DRAIN SHALL drop I2C_GO/fifo_snd_vld/fifo_rcv_rdy next cycle and go to RESP with RSP_ERR[1]=1, RSP_RDATA=0.
REQ-020 I2C_DONE while not in RUN SHALL be ignored.

Reset
REQ-021 RESET_N low SHALL force IDLE and all outputs 0 (REQ_RDY, RSP_VLD, RSP_RDATA, RSP_ERR, fifo_snd_*, fifo_rcv_rdy, I2C_GO, I2C_RUN_NUM).
REQ-022 Reset mid-transaction SHALL discard captured request with no response generated.

Configuration
REQ-023 With I2C_MASTER_SEQ_TIMEOUT_EN defined, a 32-bit counter SHALL run in RUN; reaching P_TIMEOUT_CYC SHALL behave as REQ-019 (RSP_ERR[1]=1).
REQ-024 Without I2C_MASTER_SEQ_TIMEOUT_EN, no counter SHALL exist and RUN waits for I2C_DONE indefinitely.

Structure
REQ-025 Package i2c_master_seq_pkg SHALL hold ctl bit positions, state encoding, RSP_ERR bit positions and max entry count (7).
REQ-026 Sub-module i2c_master_seq_entry SHALL combinationally map (entry index, captured request) to fifo_snd_dat/ctl.

Verification
REQ-027 Write dev 0x50 reg 0x10 len 1 wdata 0x0000BBAA -> entries (A0,03),(10,02),(AA,02),(BB,0A), RUN_NUM=4, GO until DONE, RSP_ERR=0, RSP_RDATA=0.
REQ-028 Read dev 0x50 reg 0x10 len 0, rcv items ack=1 last dat 0x5A -> entries (A0,03),(10,02),(A1,12),(FF,0C), RSP_RDATA=0x0000005A.
REQ-029 fifo_snd_rdy toggling 1/0 during LOAD -> no entry dropped or duplicated, dat/ctl stable while stalled.
REQ-030 Write with second drain item ack=0 -> RSP_ERR=2'b01 after all 4 items popped.
REQ-031 I2C_EN dropped in RUN -> GO low next cycle, RSP_ERR=2'b10; with TIMEOUT_EN and P_TIMEOUT_CYC=16, no DONE -> RSP_ERR=2'b10 at cycle 16.
REQ-032 RSP_RDY held low 5 cycles -> RSP_VLD/RSP_RDATA stable, REQ_RDY=0 throughout.
